// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg -- shared definitions for the PS/2 host interface.
//   * transmit FSM state encoding
//   * default inhibit / watchdog lengths in CLOCK_50 cycles
//   * counter widths
//   * keyboard command bytes and the receive-side scan/response codes
//   * odd_parity(): parity bit appended to every host->device byte
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQUEST   = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } tx_state_e;

  // 100 us and 15 ms at 50 MHz
  localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 750000;

  localparam int BIT_CNT_W = 4;
  localparam int INH_CNT_W = 13;
  localparam int WD_CNT_W  = 20;

  // Keyboard commands (host -> device)
  localparam logic [7:0] KBD_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] KBD_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] KBD_CMD_RESET    = 8'hFF;

  // Codes seen by the receive driver (device -> host)
  localparam logic [7:0] PS2_RX_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RX_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_RX_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RX_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_RX_EXTENDED = 8'hE0;

  // PS/2 frames use odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge -- brings the asynchronous PS/2 clock and data lines into the
// CLOCK_50 domain and flags falling edges of the PS/2 clock.
//   CLOCK_50  in  system clock
//   RESET     in  asynchronous active-high reset
//   clk_in    in  raw PS/2 clock line level
//   dat_in    in  raw PS/2 data line level
//   clk_sync  out synchronized PS/2 clock
//   dat_sync  out synchronized PS/2 data (same latency as clk_sync)
//   clk_fall  out one-cycle pulse: synced clock was 1, is now 0
// ---------------------------------------------------------------------------
module ps2_sync_edge (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic dat_meta_q, dat_meta_d;
  logic dat_sync_q, dat_sync_d;

  always_comb begin
    clk_meta_d = clk_in;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = dat_in;
    dat_sync_d = dat_meta_q;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      clk_meta_q <= 1'b0;
      clk_sync_q <= 1'b0;
      clk_prev_q <= 1'b0;
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
    end
  end

  assign clk_sync = clk_sync_q;
  assign dat_sync = dat_sync_q;
  assign clk_fall = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx -- host-to-device PS/2 byte transmitter.
// Inhibits the bus, issues a request-to-send, shifts 8 data bits + odd parity
// on device-generated clock falls, releases for the stop bit, samples the
// device ACK and waits for the bus to go idle. A watchdog aborts a stuck
// transfer.
//   CLOCK_50    in  system clock
//   RESET       in  asynchronous active-high reset
//   send        in  one-cycle transmit request (ignored while busy)
//   tx_data     in  byte to send, captured on an accepted send
//   PS2_CLK/DAT in  sensed bus levels
//   PS2_CLK_OE  out 1 = pull clock low
//   PS2_DAT_OE  out 1 = pull data low
//   busy        out transfer in progress
//   done        out one-cycle pulse: finished, device acknowledged
//   ack_err     out one-cycle pulse: finished, no acknowledge
//   timeout     out one-cycle pulse: watchdog abort
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam logic [INH_CNT_W-1:0] INH_LAST = INH_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_CNT_W-1:0]  WD_LAST  = WD_CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_s, dat_s, clk_fall;

  ps2_sync_edge u_sync (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .clk_in   (PS2_CLK),
    .dat_in   (PS2_DAT),
    .clk_sync (clk_s),
    .dat_sync (dat_s),
    .clk_fall (clk_fall)
  );

  tx_state_e            state_q,   state_d;
  logic [8:0]           shift_q,   shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [INH_CNT_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [WD_CNT_W-1:0]  wd_cnt_q,  wd_cnt_d;
  logic                 ack_ok_q,  ack_ok_d;
  logic                 clk_oe_q,  clk_oe_d;
  logic                 dat_oe_q,  dat_oe_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic                 ack_err_q, ack_err_d;
  logic                 timeout_q, timeout_d;
  logic                 wd_active;

  assign wd_active = (state_q == REQUEST) || (state_q == SHIFT) ||
                     (state_q == ACK)     || (state_q == WAIT_IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    ack_ok_d  = ack_ok_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        if (send) begin
          shift_d   = {odd_parity(tx_data), tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          ack_ok_d  = 1'b0;
          clk_oe_d  = 1'b1;
          // With a one-cycle inhibit the first cycle is also the last one.
          dat_oe_d  = (INH_LAST == '0);
          busy_d    = 1'b1;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (inh_cnt_q >= INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          wd_cnt_d = '0;
          state_d  = REQUEST;
        end else begin
          inh_cnt_d = (inh_cnt_q == '1) ? inh_cnt_q : inh_cnt_q + 1'b1;
          // Outputs are registered, so the start bit is scheduled one
          // cycle ahead to land on the final inhibit cycle.
          dat_oe_d  = (inh_cnt_q + 1'b1 == INH_LAST);
        end
      end

      REQUEST: begin
        if (clk_fall) begin
          dat_oe_d  = ~shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bit_cnt_d = BIT_CNT_W'(1);
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (clk_fall) begin
          if (bit_cnt_q >= BIT_CNT_W'(9)) begin
            // tenth fall: release data for the stop bit
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end else begin
            dat_oe_d  = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
            bit_cnt_d = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 1'b1;
          end
        end
      end

      ACK: begin
        if (clk_fall) begin
          ack_ok_d = ~dat_s;
          state_d  = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d    = ack_ok_q;
          ack_err_d = ~ack_ok_q;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase

    // Watchdog overrides every other outcome so the pulses stay exclusive.
    if (wd_active) begin
      wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
      if (wd_cnt_q >= WD_LAST) begin
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      wd_cnt_q  <= '0;
      ack_ok_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      ack_ok_q  <= ack_ok_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign PS2_CLK_OE = clk_oe_q;
  assign PS2_DAT_OE = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ack_err    = ack_err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 800;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       send;
  logic [7:0] tx_data;
  logic       PS2_CLK, PS2_DAT;
  logic       PS2_CLK_OE, PS2_DAT_OE;
  logic       busy, done, ack_err, timeout;

  // device side of the open-collector bus
  logic dev_clk_high;
  logic dev_dat_low;

  assign PS2_CLK = dev_clk_high & ~PS2_CLK_OE;
  assign PS2_DAT = ~dev_dat_low & ~PS2_DAT_OE;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .send       (send),
    .tx_data    (tx_data),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .PS2_CLK_OE (PS2_CLK_OE),
    .PS2_DAT_OE (PS2_DAT_OE),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout    (timeout)
  );

  // completion pulse counters (cycles high)
  int n_done = 0, n_err = 0, n_to = 0, n_multi = 0;
  always @(negedge CLOCK_50) begin
    if (!RESET) begin
      n_done <= n_done + int'(done);
      n_err  <= n_err + int'(ack_err);
      n_to   <= n_to + int'(timeout);
      if (int'(done) + int'(ack_err) + int'(timeout) > 1) n_multi <= n_multi + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: frame the host must put on the wire = data LSB first,
  // parity making the count of ones odd, stop bit 1.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d};
  endfunction

  // One host transmission with a device model clocking it.
  // rst_edge: 0 = none, else assert RESET after that falling edge.
  // dup: issue a second send (0x55) during the data phase.
  task automatic xfer(input logic [7:0] d, input bit ack, input int half,
                      input int rst_edge, input bit dup);
    int d0, e0, t0, inh_n, both_n, guard;
    logic [9:0] smp, exp_f;
    logic exp_oe;
    d0 = n_done; e0 = n_err; t0 = n_to;
    smp = '0;
    exp_f = ref_frame(d);

    @(negedge CLOCK_50); tx_data = d; send = 1'b1;
    @(negedge CLOCK_50); send = 1'b0;
    check_val("busy_rise", busy, 1);

    inh_n = 0; both_n = 0; guard = 0;
    while (PS2_CLK_OE && guard < 10000) begin
      inh_n++;
      if (PS2_DAT_OE) both_n++;
      guard++;
      @(negedge CLOCK_50);
    end
    check_val("inhibit_len", inh_n, INH);
    check_val("start_on_last_inhibit", both_n, 1);
    check_val("start_bit", PS2_DAT, 0);
    repeat (4) @(negedge CLOCK_50);

    for (int e = 1; e <= 11; e++) begin
      dev_clk_high = 1'b0;
      for (int c = 0; c < half; c++) begin
        if (dup && e == 3 && c == 0) begin
          send = 1'b1; tx_data = 8'h55;
        end else begin
          send = 1'b0;
        end
        @(negedge CLOCK_50);
      end
      send = 1'b0;
      if (e == rst_edge) begin
        exp_oe = ~exp_f[e-1];
        check_val("pre_reset_dat_oe", PS2_DAT_OE, exp_oe);
        #2 RESET = 1'b1;
        #1;
        check_val("rst_clk_oe", PS2_CLK_OE, 0);
        check_val("rst_dat_oe", PS2_DAT_OE, 0);
        check_val("rst_busy", busy, 0);
        dev_clk_high = 1'b1;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (60) @(negedge CLOCK_50);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_pulses", (n_done - d0) + (n_err - e0) + (n_to - t0), 0);
        $display("tx %02h reset after edge %0d", d, e);
        return;
      end
      if (e <= 10) smp[e-1] = PS2_DAT;
      dev_clk_high = 1'b1;
      if (e == 10) dev_dat_low = ack;
      repeat (half) @(negedge CLOCK_50);
    end
    dev_dat_low = 1'b0;

    guard = 0;
    while (busy && guard < 200) begin
      guard++;
      @(negedge CLOCK_50);
    end
    check_val("busy_fall", busy, 0);
    repeat (3) @(negedge CLOCK_50);

    check_val("data_bits", smp[7:0], exp_f[7:0]);
    check_val("parity_bit", smp[8], exp_f[8]);
    check_val("stop_bit", smp[9], exp_f[9]);
    check_val("done_cnt", n_done - d0, ack ? 1 : 0);
    check_val("ack_err_cnt", n_err - e0, ack ? 0 : 1);
    check_val("timeout_cnt", n_to - t0, 0);
    check_val("idle_oe", {PS2_CLK_OE, PS2_DAT_OE}, 0);
    $display("tx %02h ack=%0d half=%0d dup=%0d frame=%03h", d, ack, half, dup, smp);
  endtask

  // Device never clocks: watchdog must end the transfer.
  task automatic tmo_test(input logic [7:0] d);
    int d0, e0, t0, n;
    d0 = n_done; e0 = n_err; t0 = n_to;
    @(negedge CLOCK_50); tx_data = d; send = 1'b1;
    @(negedge CLOCK_50); send = 1'b0;
    n = 0;
    while (!timeout && n < INH + TMO + 100) begin
      n++;
      @(negedge CLOCK_50);
    end
    check_val("tmo_latency_ok", (n >= INH + TMO) && (n <= INH + TMO + 2), 1);
    check_val("tmo_clk_oe", PS2_CLK_OE, 0);
    check_val("tmo_dat_oe", PS2_DAT_OE, 0);
    repeat (3) @(negedge CLOCK_50);
    check_val("tmo_busy", busy, 0);
    check_val("tmo_pulse", n_to - t0, 1);
    check_val("tmo_no_done", (n_done - d0) + (n_err - e0), 0);
    $display("tx %02h timeout after %0d cycles", d, n);
  endtask

  initial begin
    logic [7:0] rd;
    bit ra;
    RESET = 1'b1; send = 1'b0; tx_data = '0;
    dev_clk_high = 1'b1; dev_dat_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_val("reset_outputs",
              {PS2_CLK_OE, PS2_DAT_OE, busy, done, ack_err, timeout}, 0);
    RESET = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    xfer(KBD_CMD_SET_LEDS, 1'b1, 8, 0, 1'b0);
    xfer(KBD_CMD_ENABLE,   1'b1, 8, 0, 1'b0);
    xfer(8'h00,            1'b1, 8, 0, 1'b0);
    xfer(KBD_CMD_RESET,    1'b0, 8, 0, 1'b0);
    tmo_test(KBD_CMD_SET_LEDS);
    xfer(KBD_CMD_SET_LEDS, 1'b1, 8, 0, 1'b1);
    xfer(KBD_CMD_SET_LEDS, 1'b1, 8, 5, 1'b0);
    xfer(KBD_CMD_ENABLE,   1'b1, 8, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      xfer(rd, ra, $urandom_range(5, 12), 0, 1'b0);
    end

    check_val("pulse_exclusive", n_multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // safety net against a hung run
  initial begin
    #20ms;
    $display("FAIL global_timeout: got=hang exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
